// File: rtl/tdr_multishot_capture_if.sv
// Result stream from the TDR capture engine: one accumulated bin per transfer, valid/ready handshake.
interface tdr_multishot_capture_if #(
  parameter int ACC_W = 13,
  parameter int IDX_W = 5
);
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [IDX_W-1:0] out_index;
  logic             out_last;

  modport master (output out_valid, out_data, out_index, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/tdr_multishot_capture.sv
// TDR capture: pulse, programmable delay, WINDOW-sample capture summed over N shots, then bins streamed out.
// First bin is presented the cycle after the last capture; stream holds data/index/last while out_ready is low.
module tdr_multishot_capture #(
  parameter  int SAMPLE_W  = 8,
  parameter  int WINDOW    = 32,
  parameter  int MAX_DELAY = 255,
  parameter  int MAX_SHOTS = 16,
  localparam int DELAY_W   = $clog2(MAX_DELAY + 1),
  localparam int SHOT_W    = $clog2(MAX_SHOTS + 1),
  localparam int ACC_W     = SAMPLE_W + SHOT_W,
  localparam int IDX_W     = $clog2(WINDOW)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                trigger,
  input  logic [DELAY_W-1:0]  delay_cfg,
  input  logic [SHOT_W-1:0]   shots_cfg,
  output logic                tx_pulse,
  input  logic [SAMPLE_W-1:0] rx_sample,
  tdr_multishot_capture_if.master out_if,
  output logic                busy,
  output logic                done,
  output logic                overrun
);

  typedef enum logic [2:0] {IDLE, FIRE, WAIT, CAPTURE, STREAM} state_t;

  state_t             state;
  logic [DELAY_W-1:0] delay_q;
  logic [DELAY_W-1:0] wait_cnt;
  logic [SHOT_W-1:0]  shots_q;
  logic [SHOT_W-1:0]  shot_cnt;
  logic [SHOT_W-1:0]  shots_clamped;
  logic [IDX_W-1:0]   idx;
  logic               out_valid_q;
  logic               out_last_q;
  logic [ACC_W-1:0]   out_data_q;
  logic [ACC_W-1:0]   acc [WINDOW];

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  always_comb begin
    shots_clamped = shots_cfg;
    if (shots_cfg == '0)
      shots_clamped = SHOT_W'(1);
    else if (shots_cfg > SHOT_W'(MAX_SHOTS))
      shots_clamped = SHOT_W'(MAX_SHOTS);
  end

  assign busy    = (state != IDLE);
  assign overrun = trigger && busy;

  assign out_if.out_valid = out_valid_q;
  assign out_if.out_data  = out_data_q;
  assign out_if.out_index = idx;
  assign out_if.out_last  = out_last_q;

  // Shot 0 overwrites, so the array needs no reset or clear pass.
  always_ff @(posedge clk) begin
    if (state == CAPTURE)
      acc[idx] <= (shot_cnt == '0) ? ACC_W'(rx_sample) : acc[idx] + ACC_W'(rx_sample);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      delay_q     <= '0;
      wait_cnt    <= '0;
      shots_q     <= '0;
      shot_cnt    <= '0;
      idx         <= '0;
      tx_pulse    <= 1'b0;
      done        <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      tx_pulse <= 1'b0;
      done     <= 1'b0;
      if (state != IDLE && !enable) begin
        state       <= IDLE;
        idx         <= '0;
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (trigger && enable) begin
              delay_q  <= delay_cfg;
              shots_q  <= shots_clamped;
              shot_cnt <= '0;
              tx_pulse <= 1'b1;
              state    <= FIRE;
            end
          end
          FIRE: begin
            idx <= '0;
            if (delay_q != '0) begin
              wait_cnt <= delay_q - DELAY_W'(1);
              state    <= WAIT;
            end else begin
              state <= CAPTURE;
            end
          end
          WAIT: begin
            if (wait_cnt == '0)
              state <= CAPTURE;
            else
              wait_cnt <= wait_cnt - DELAY_W'(1);
          end
          CAPTURE: begin
            if (idx == LAST_IDX) begin
              idx <= '0;
              if (shot_cnt < shots_q - SHOT_W'(1)) begin
                shot_cnt <= shot_cnt + SHOT_W'(1);
                tx_pulse <= 1'b1;
                state    <= FIRE;
              end else begin
                // Bin 0 is already final while the last bin is being written.
                out_valid_q <= 1'b1;
                out_last_q  <= 1'b0;
                out_data_q  <= acc[0];
                state       <= STREAM;
              end
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
          STREAM: begin
            if (out_if.out_ready) begin
              if (idx == LAST_IDX) begin
                idx         <= '0;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
                done        <= 1'b1;
                state       <= IDLE;
              end else begin
                idx        <= idx + IDX_W'(1);
                out_data_q <= acc[idx + IDX_W'(1)];
                out_last_q <= ((idx + IDX_W'(1)) == LAST_IDX);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdr_multishot_capture.sv
// Randomized bench for tdr_multishot_capture: expected bins and pulse times come from the timing rules.
module tb_tdr_multishot_capture;
  localparam int WINDOW = 32;
  localparam int RXN    = 8192;

  typedef struct {
    logic [12:0] data;
    logic [4:0]  idx;
    logic        last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       trigger;
  logic [7:0] delay_cfg;
  logic [4:0] shots_cfg;
  logic       tx_pulse;
  logic [7:0] rx_sample;
  logic       busy;
  logic       done;
  logic       overrun;

  tdr_multishot_capture_if #(.ACC_W(13), .IDX_W(5)) oif ();

  tdr_multishot_capture dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .trigger   (trigger),
    .delay_cfg (delay_cfg),
    .shots_cfg (shots_cfg),
    .tx_pulse  (tx_pulse),
    .rx_sample (rx_sample),
    .out_if    (oif),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
  );

  int         checks;
  int         failures;
  int         cyc;
  int         done_cnt;
  int         exp_done;
  int         ovr_cnt;
  int         last_xfer;
  int         ready_mode;
  int         hold_left;
  logic [7:0] rx_mem [RXN];
  exp_t       sb_q [$];
  int         tx_q [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // rx_sample for cycle n is rx_mem[n]; ready follows the selected pattern.
  initial begin
    rx_sample = '0;
    oif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rx_sample = rx_mem[cyc % RXN];
      case (ready_mode)
        0: oif.out_ready = 1'b1;
        1: oif.out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (hold_left > 0 && oif.out_valid) begin
            oif.out_ready = 1'b0;
            hold_left--;
          end else begin
            oif.out_ready = 1'($urandom_range(0, 1));
          end
        end
      endcase
    end
  end

  // Monitor: pulse timing, scoreboard pops, stall stability, done placement.
  initial begin
    exp_t        e;
    int          t;
    bit          prev_stall;
    logic [12:0] pd;
    logic [4:0]  pi;
    logic        pl;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        continue;
      end
      if (tx_pulse) begin
        if (tx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected actual=pulse@%0d expected=none", cyc);
        end else begin
          t = tx_q.pop_front();
          chk("tx_cycle", 32'(cyc), 32'(t));
        end
      end
      if (prev_stall) begin
        chk("stall_valid", 32'(oif.out_valid), 32'd1);
        chk("stall_data", 32'(oif.out_data), 32'(pd));
        chk("stall_index", 32'(oif.out_index), 32'(pi));
        chk("stall_last", 32'(oif.out_last), 32'(pl));
      end
      if (oif.out_valid && oif.out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual=bin%0d expected=none", oif.out_index);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", 32'(oif.out_data), 32'(e.data));
          chk("out_index", 32'(oif.out_index), 32'(e.idx));
          chk("out_last", 32'(oif.out_last), 32'(e.last));
        end
        if (oif.out_last) last_xfer = cyc;
      end
      prev_stall = oif.out_valid && !oif.out_ready;
      pd = oif.out_data;
      pi = oif.out_index;
      pl = oif.out_last;
      if (done) begin
        done_cnt++;
        chk("done_after_last", 32'(cyc), 32'(last_xfer + 1));
        chk("done_valid_low", 32'(oif.out_valid), 32'd0);
      end
      if (overrun) ovr_cnt++;
    end
  end

  // Called at #1 after an edge with the DUT idle; bin k of shot s is the sample in
  // cycle T_s+1+d+k, where T_0 is the cycle after the trigger and shots are d+WINDOW+1 apart.
  task automatic start_run(input int d, input int scfg, input int mode, input int ntx, input bit push_bins);
    int          c;
    int          s_eff;
    int          t0;
    int          tt;
    logic [7:0]  v;
    logic [12:0] acc [WINDOW];
    exp_t        e;
    c = cyc;
    s_eff = (scfg == 0) ? 1 : ((scfg > 16) ? 16 : scfg);
    for (int k = 0; k < WINDOW; k++) acc[k] = '0;
    for (int s = 0; s < s_eff; s++) begin
      t0 = c + 1 + s * (d + WINDOW + 1);
      if (ntx < 0 || s < ntx) tx_q.push_back(t0);
      for (int k = 0; k < WINDOW; k++) begin
        tt = t0 + 1 + d + k;
        case (mode)
          1: v = 8'hFF;
          2: v = 8'(k);
          default: v = 8'($urandom_range(0, 255));
        endcase
        rx_mem[tt % RXN] = v;
        acc[k] = acc[k] + 13'(v);
      end
    end
    if (push_bins) begin
      for (int k = 0; k < WINDOW; k++) begin
        e.data = acc[k];
        e.idx  = 5'(k);
        e.last = (k == WINDOW - 1);
        sb_q.push_back(e);
      end
    end
    delay_cfg = 8'(d);
    shots_cfg = 5'(scfg);
    trigger   = 1'b1;
    @(posedge clk);
    #1;
    trigger   = 1'b0;
    delay_cfg = 8'($urandom_range(0, 255));
    shots_cfg = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk);
      #1;
      if (done) got = 1'b1;
    end
    chk("done_seen", 32'(got), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("bins_left", 32'(sb_q.size()), 32'd0);
    chk("tx_left", 32'(tx_q.size()), 32'd0);
    if (got) exp_done++;
  endtask

  initial begin
    bit found;
    int d;
    int s;
    checks = 0;
    failures = 0;
    done_cnt = 0;
    exp_done = 0;
    ovr_cnt = 0;
    last_xfer = -10;
    ready_mode = 0;
    hold_left = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    trigger = 1'b0;
    delay_cfg = '0;
    shots_cfg = '0;
    for (int i = 0; i < RXN; i++) rx_mem[i] = 8'($urandom_range(0, 255));

    #12;
    chk("rst_tx", 32'(tx_pulse), 32'd0);
    chk("rst_valid", 32'(oif.out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_last", 32'(oif.out_last), 32'd0);
    chk("rst_data", 32'(oif.out_data), 32'd0);
    chk("rst_index", 32'(oif.out_index), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    start_run(5, 1, 2, -1, 1);
    chk("busy_running", 32'(busy), 32'd1);
    wait_done(300);
    start_run(0, 4, 1, -1, 1);
    wait_done(400);
    start_run(3, 16, 1, -1, 1);
    wait_done(900);
    start_run(4, 0, 0, -1, 1);
    wait_done(300);
    start_run(1, 31, 0, -1, 1);
    wait_done(900);

    ready_mode = 2;
    hold_left = 10;
    start_run(2, 3, 0, -1, 1);
    wait_done(600);
    ready_mode = 0;

    // Trigger during WAIT is reported and otherwise ignored.
    start_run(20, 1, 0, -1, 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    trigger = 1'b1;
    @(negedge clk);
    chk("overrun_in_wait", 32'(overrun), 32'd1);
    @(posedge clk);
    #1;
    trigger = 1'b0;
    @(negedge clk);
    chk("overrun_cleared", 32'(overrun), 32'd0);
    wait_done(300);

    // Abort in the middle of shot 0's capture.
    start_run(3, 2, 0, 1, 0);
    repeat (1 + 3 + 10) begin
      @(posedge clk);
      #1;
    end
    enable = 1'b0;
    @(posedge clk);
    #1;
    enable = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    repeat (60) begin
      @(posedge clk);
      #1;
    end
    chk("abort_no_done", 32'(done_cnt), 32'(exp_done));
    chk("abort_tx_left", 32'(tx_q.size()), 32'd0);

    // Asynchronous reset while streaming.
    start_run(2, 1, 0, -1, 1);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (oif.out_valid && oif.out_index == 5'd5) found = 1'b1;
    end
    chk("stream_reached", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(oif.out_valid), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    sb_q.delete();
    chk("rst_mid_tx_left", 32'(tx_q.size()), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_run(7, 2, 0, -1, 1);
    wait_done(400);

    ready_mode = 1;
    for (int r = 0; r < 4; r++) begin
      d = $urandom_range(0, 40);
      s = $urandom_range(0, 20);
      start_run(d, s, 0, -1, 1);
      wait_done(16 * (d + WINDOW + 1) + 400);
    end
    ready_mode = 0;

    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("done_total", 32'(done_cnt), 32'(exp_done));
    chk("overrun_total", 32'(ovr_cnt), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
